// File: rtl/ucsbece154_mem_arbiter.sv
// rtl/ucsbece154_mem_arbiter.sv - whole-burst arbiter sharing one memory read port between I-cache and D-cache refills
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternating tie-break instead of fixed D-over-I priority).
module ucsbece154_mem_arbiter #(
    parameter int BLOCK_WORDS = 4,
    parameter int CNT_W       = $clog2(BLOCK_WORDS)
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        IReadRequest,
    input  logic [31:0] IReadAddress,
    output logic [31:0] IDataIn,
    output logic        IDataReady,

    input  logic        DReadRequest,
    input  logic [31:0] DReadAddress,
    output logic [31:0] DDataIn,
    output logic        DDataReady,

    output logic        MemReadRequest,
    output logic [31:0] MemReadAddress,
    input  logic [31:0] MemDataIn,
    input  logic        MemDataReady,

    output logic [1:0]  Grant,
    output logic        Busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_grant;
    logic             r_mem_req;
    logic [31:0]      r_mem_addr;
    logic [CNT_W-1:0] r_cnt;

    logic             w_any_req;
    logic             w_pick_d;
    logic             w_in_burst;
    logic             w_last_beat;

    assign w_any_req   = IReadRequest | DReadRequest;
    assign w_in_burst  = (r_state == S_BURST);
    assign w_last_beat = (r_cnt == CNT_W'(BLOCK_WORDS - 1));

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_d;
    // On a tie the side that did not own the previous burst wins.
    assign w_pick_d = DReadRequest & (~IReadRequest | ~r_last_d);
`else
    assign w_pick_d = DReadRequest;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_grant    <= 2'b00;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'h0000_0000;
            r_cnt      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_d   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_mem_req <= 1'b0;
                    if (w_any_req) begin
                        r_grant    <= w_pick_d ? 2'b10 : 2'b01;
                        r_mem_addr <= w_pick_d ? DReadAddress : IReadAddress;
                        r_mem_req  <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_mem_req <= 1'b0;
                    r_state   <= S_BURST;
                end
                S_BURST: begin
                    if (MemDataReady) begin
                        if (w_last_beat) begin
                            r_cnt   <= '0;
                            r_grant <= 2'b00;
                            r_state <= S_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                            r_last_d <= r_grant[1];
`endif
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_grant   <= 2'b00;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Beats outside BURST (spurious or early) are never forwarded to a cache.
    assign IDataIn        = MemDataIn;
    assign DDataIn        = MemDataIn;
    assign IDataReady     = MemDataReady & r_grant[0] & w_in_burst;
    assign DDataReady     = MemDataReady & r_grant[1] & w_in_burst;

    assign MemReadRequest = r_mem_req;
    assign MemReadAddress = r_mem_addr;
    assign Grant          = r_grant;
    assign Busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_ucsbece154_mem_arbiter.sv
// tb/tb_ucsbece154_mem_arbiter.sv - self-checking bench for ucsbece154_mem_arbiter
module tb_ucsbece154_mem_arbiter;
    localparam int BW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        IReadRequest = 1'b0, DReadRequest = 1'b0;
    logic [31:0] IReadAddress = '0, DReadAddress = '0;
    logic [31:0] IDataIn, DDataIn, MemReadAddress;
    logic        IDataReady, DDataReady, MemReadRequest, Busy;
    logic [31:0] MemDataIn = '0;
    logic        MemDataReady = 1'b0;
    logic [1:0]  Grant;

    always #5 clk = ~clk;

    ucsbece154_mem_arbiter #(.BLOCK_WORDS(BW)) dut (
        .clk(clk), .reset(reset),
        .IReadRequest(IReadRequest), .IReadAddress(IReadAddress), .IDataIn(IDataIn), .IDataReady(IDataReady),
        .DReadRequest(DReadRequest), .DReadAddress(DReadAddress), .DDataIn(DDataIn), .DDataReady(DDataReady),
        .MemReadRequest(MemReadRequest), .MemReadAddress(MemReadAddress),
        .MemDataIn(MemDataIn), .MemDataReady(MemDataReady),
        .Grant(Grant), .Busy(Busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] text_word(input int idx);
        return 32'hA500_0000 | 32'(idx);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - 32'h0001_0000) >> 2);
    endfunction

    // requester / memory environment controls
    logic [31:0] iq[$], dq[$];
    bit  i_auto = 1, d_auto = 1, hold_mode = 0, rand_req = 0, rand_gaps = 0, spurious_req = 0;
    int  mem_delay = 0;
    bit  mem_active = 0;
    logic [31:0] mem_addr = '0;
    int  mem_wait = 0, mem_beat = 0;
    bit  got_i = 0, got_d = 0;

    // reference model and observation logs
    logic [1:0]  m_grant = 2'b00;
    bit          m_issue = 0, m_last_d = 0;
    logic [31:0] m_addr = '0;
    int          m_beats = 0;
    int          cyc = 0, tot_i = 0, tot_d = 0, pulses = 0, i_last_cyc = 0;
    logic [1:0]  glog[$];
    logic [31:0] alog[$], ilog[$], dlog[$];
    int          gcyc[$];

    // memory model and requesters drive at the falling edge
    always @(negedge clk) begin
        if (reset) begin
            mem_active   = 0;
            MemDataReady = 1'b0;
        end else begin
            MemDataReady = 1'b0;
            if (mem_active) begin
                if (mem_wait > 0) mem_wait--;
                else begin
                    MemDataReady = 1'b1;
                    MemDataIn    = text_word(word_of(mem_addr) + mem_beat);
                    mem_beat++;
                    if (mem_beat == BW) mem_active = 0;
                    else mem_wait = rand_gaps ? $urandom_range(0, 2) : 0;
                end
            end else if (spurious_req && m_grant == 2'b00) begin
                MemDataReady = 1'b1;
                MemDataIn    = 32'hDEAD_BEEF;
                spurious_req = 0;
            end
            if (MemReadRequest) begin
                mem_active = 1; mem_addr = MemReadAddress; mem_wait = mem_delay; mem_beat = 0;
            end
            if (i_auto) begin
                if (IReadRequest && got_i) begin
                    if (hold_mode && iq.size() > 0) IReadAddress = iq.pop_front();
                    else IReadRequest = 1'b0;
                end else if (!IReadRequest && iq.size() > 0 && (!rand_req || $urandom_range(0, 2) == 0)) begin
                    IReadRequest = 1'b1; IReadAddress = iq.pop_front();
                end
            end
            if (d_auto) begin
                if (DReadRequest && got_d) begin
                    if (hold_mode && dq.size() > 0) DReadAddress = dq.pop_front();
                    else DReadRequest = 1'b0;
                end else if (!DReadRequest && dq.size() > 0 && (!rand_req || $urandom_range(0, 2) == 0)) begin
                    DReadRequest = 1'b1; DReadAddress = dq.pop_front();
                end
            end
        end
    end

    // Transaction-level reference: a burst owner is chosen from the requests seen while free,
    // announced the next cycle, and held until BW memory beats have been delivered after the issue cycle.
    always @(negedge clk) begin
        bit exp_i, exp_d, pick_d;
        #1;
        cyc++;
        if (reset) begin
            m_grant = 2'b00; m_issue = 0; m_beats = 0; m_last_d = 0; m_addr = '0;
            tot_i = 0; tot_d = 0; got_i = 0; got_d = 0;
        end else begin
            chk("grant", Grant, m_grant);
            chk("busy", Busy, m_grant != 2'b00);
            chk("memreq", MemReadRequest, m_issue);
            if (m_issue) chk("memaddr", MemReadAddress, m_addr);
            exp_i = MemDataReady && m_grant == 2'b01 && !m_issue;
            exp_d = MemDataReady && m_grant == 2'b10 && !m_issue;
            chk("irdy", IDataReady, exp_i);
            chk("drdy", DDataReady, exp_d);
            if (exp_i && IDataReady) chk("idata", IDataIn, text_word(word_of(m_addr) + m_beats));
            if (exp_d && DDataReady) chk("ddata", DDataIn, text_word(word_of(m_addr) + m_beats));
            got_i = IDataReady && (tot_i % BW == 0);
            got_d = DDataReady && (tot_d % BW == 0);
            if (IDataReady) begin
                tot_i++; ilog.push_back(IDataIn);
                if (tot_i % BW == 0) i_last_cyc = cyc;
            end
            if (DDataReady) begin tot_d++; dlog.push_back(DDataIn); end
            if (MemReadRequest) begin
                pulses++; glog.push_back(Grant); alog.push_back(MemReadAddress); gcyc.push_back(cyc);
            end
            if (m_grant == 2'b00) begin
                if (IReadRequest || DReadRequest) begin
`ifdef ARB_ROUND_ROBIN_EN
                    pick_d = DReadRequest && (!IReadRequest || !m_last_d);
`else
                    pick_d = DReadRequest;
`endif
                    m_grant = pick_d ? 2'b10 : 2'b01;
                    m_addr  = pick_d ? DReadAddress : IReadAddress;
                    m_issue = 1; m_beats = 0;
                end
            end else if (m_issue) begin
                m_issue = 0;
            end else if (MemDataReady) begin
                m_beats++;
                if (m_beats == BW) begin
                    m_last_d = (m_grant == 2'b10); m_grant = 2'b00; m_beats = 0;
                end
            end
        end
    end

    task automatic clear_logs();
        pulses = 0; glog.delete(); alog.delete(); gcyc.delete(); ilog.delete(); dlog.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        iq.delete(); dq.delete();
        IReadRequest = 1'b0; DReadRequest = 1'b0;
        spurious_req = 0; hold_mode = 0; rand_req = 0; rand_gaps = 0; i_auto = 1; d_auto = 1;
        @(negedge clk); @(negedge clk); #3;
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin @(negedge clk); #2; n++; end
        while (!(iq.size() == 0 && dq.size() == 0 && !IReadRequest && !DReadRequest &&
                 m_grant == 2'b00 && !m_issue && !mem_active) && n < 5000);
        checks++;
        if (n >= 5000) begin failures++; $display("FAIL timeout_%s actual=busy expected=idle", tag); end
    endtask

    task automatic wait_i_beats(input int k, input string tag);
        int n = 0;
        while (tot_i < k && n < 2000) begin @(negedge clk); #2; n++; end
        checks++;
        if (tot_i < k) begin failures++; $display("FAIL timeout_%s actual=%0d expected=%0d", tag, tot_i, k); end
    endtask

    typedef struct {
        bit ireq; bit dreq; logic [31:0] ia; logic [31:0] da; int delay;
        logic [1:0] g0; logic [31:0] a0; logic [1:0] g1;
        int bursts; int ibeats; int dbeats; int ifirst; int dfirst;
    } vec_t;
    vec_t vecs[4];
    logic [1:0] exp_order[4];
    int pushed;

    initial begin
        vecs[0] = '{1, 0, 32'h0001_0010, 32'h0, 40, 2'b01, 32'h0001_0010, 2'b00, 1, 4, 0, 4, -1};
        vecs[1] = '{0, 1, 32'h0, 32'h0001_0040, 3, 2'b10, 32'h0001_0040, 2'b00, 1, 0, 4, -1, 16};
        vecs[2] = '{1, 1, 32'h0001_0000, 32'h0001_0020, 5, 2'b10, 32'h0001_0020, 2'b01, 2, 4, 4, 0, 8};
        vecs[3] = '{1, 1, 32'h0001_03F0, 32'h0001_0000, 0, 2'b10, 32'h0001_0000, 2'b01, 2, 4, 4, 252, 0};
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
        exp_order = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif

        @(negedge clk); #2;
        chk("rst_grant", Grant, 2'b00);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_memreq", MemReadRequest, 1'b0);
        chk("rst_memaddr", MemReadAddress, 32'h0);
        chk("rst_irdy", IDataReady, 1'b0);
        chk("rst_drdy", DDataReady, 1'b0);

        for (int v = 0; v < 4; v++) begin
            do_reset();
            mem_delay = vecs[v].delay;
            if (vecs[v].ireq) iq.push_back(vecs[v].ia);
            if (vecs[v].dreq) dq.push_back(vecs[v].da);
            wait_idle($sformatf("v%0d", v));
            chk($sformatf("v%0d_pulses", v), pulses, vecs[v].bursts);
            chk($sformatf("v%0d_g0", v), glog.size() > 0 ? glog[0] : 2'b11, vecs[v].g0);
            chk($sformatf("v%0d_a0", v), alog.size() > 0 ? alog[0] : 32'hFFFF_FFFF, vecs[v].a0);
            if (vecs[v].bursts > 1)
                chk($sformatf("v%0d_g1", v), glog.size() > 1 ? glog[1] : 2'b11, vecs[v].g1);
            chk($sformatf("v%0d_ibeats", v), ilog.size(), vecs[v].ibeats);
            chk($sformatf("v%0d_dbeats", v), dlog.size(), vecs[v].dbeats);
            if (vecs[v].ifirst >= 0 && ilog.size() == BW) begin
                chk($sformatf("v%0d_ifirst", v), ilog[0], text_word(vecs[v].ifirst));
                chk($sformatf("v%0d_ilast", v), ilog[BW-1], text_word(vecs[v].ifirst + BW - 1));
            end
            if (vecs[v].dfirst >= 0 && dlog.size() == BW)
                chk($sformatf("v%0d_dfirst", v), dlog[0], text_word(vecs[v].dfirst));
        end

        // D request raised during beat 2 of an I burst waits for the dead cycle
        do_reset();
        mem_delay = 6;
        iq.push_back(32'h0001_0000);
        wait_i_beats(2, "mid_i");
        dq.push_back(32'h0001_0030);
        wait_idle("mid");
        chk("mid_pulses", pulses, 2);
        chk("mid_g0", glog.size() > 0 ? glog[0] : 2'b11, 2'b01);
        chk("mid_g1", glog.size() > 1 ? glog[1] : 2'b11, 2'b10);
        chk("mid_dgrant_cyc", gcyc.size() > 1 ? gcyc[1] : -1, i_last_cyc + 2);

        // both sides held continuously for several bursts
        do_reset();
        mem_delay = 2; hold_mode = 1;
        for (int k = 0; k < 4; k++) begin
            iq.push_back(32'h0001_0100 + 32'(k * 16));
            dq.push_back(32'h0001_0200 + 32'(k * 16));
        end
        wait_idle("order");
        chk("order_pulses", pulses, 8);
        for (int k = 0; k < 4; k++)
            chk($sformatf("order_g%0d", k), glog.size() > k ? glog[k] : 2'b11, exp_order[k]);

        // I request withdrawn before it was ever granted
        do_reset();
        mem_delay = 10; i_auto = 0;
        dq.push_back(32'h0001_0080);
        @(negedge clk); @(negedge clk);
        IReadRequest = 1'b1; IReadAddress = 32'h0001_0090;
        @(negedge clk); @(negedge clk); @(negedge clk);
        IReadRequest = 1'b0;
        wait_idle("drop");
        i_auto = 1;
        chk("drop_pulses", pulses, 1);
        chk("drop_g0", glog.size() > 0 ? glog[0] : 2'b11, 2'b10);
        chk("drop_ibeats", ilog.size(), 0);

        // asynchronous reset at beat 2
        do_reset();
        mem_delay = 4;
        iq.push_back(32'h0001_0050);
        wait_i_beats(2, "rst_mid");
        iq.delete(); IReadRequest = 1'b0; DReadRequest = 1'b0;
        reset = 1'b1;
        #1;
        chk("arst_grant", Grant, 2'b00);
        chk("arst_busy", Busy, 1'b0);
        chk("arst_memreq", MemReadRequest, 1'b0);
        chk("arst_irdy", IDataReady, 1'b0);
        @(negedge clk); @(negedge clk); #3;
        reset = 1'b0;
        clear_logs();
        iq.push_back(32'h0001_0060);
        wait_idle("after_rst");
        chk("after_rst_pulses", pulses, 1);
        chk("after_rst_ibeats", ilog.size(), BW);

        // spurious beat while idle
        do_reset();
        mem_delay = 3;
        spurious_req = 1;
        repeat (4) @(negedge clk);
        #2;
        chk("spur_consumed", spurious_req, 1'b0);
        chk("spur_ibeats", ilog.size(), 0);
        chk("spur_dbeats", dlog.size(), 0);
        iq.push_back(32'h0001_0070);
        wait_idle("spur");
        chk("spur_pulses", pulses, 1);
        chk("spur_burst_beats", ilog.size(), BW);

        // randomized traffic against the reference model
        do_reset();
        pushed = 0;
        rand_req = 1; rand_gaps = 1;
        for (int it = 0; it < 40; it++) begin
            int ni, nd;
            mem_delay = $urandom_range(0, 8);
            hold_mode = $urandom_range(0, 1);
            ni = $urandom_range(0, 2);
            nd = $urandom_range(0, 2);
            for (int k = 0; k < ni; k++) iq.push_back(32'h0001_0000 + ($urandom_range(0, 63) << 4));
            for (int k = 0; k < nd; k++) dq.push_back(32'h0001_0000 + ($urandom_range(0, 63) << 4));
            pushed += ni + nd;
            if ($urandom_range(0, 3) == 0) spurious_req = 1;
            wait_idle($sformatf("rand%0d", it));
        end
        spurious_req = 0;
        chk("rand_pulses", pulses, pushed);
        chk("rand_beats", ilog.size() + dlog.size(), pushed * BW);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
